// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and coordinate/lives widths for the round controller
package game_pkg;
  localparam int COORD_W = 5;
  localparam int LIVES_W = 2;
  typedef enum logic [1:0] {IDLE, SPAWN, PLAY, OVER} state_t;
endpackage

// File: rtl/hit_detect.sv
// hit_detect: cursor-on-target equality compare
module hit_detect
  import game_pkg::*;
(
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic [COORD_W-1:0] tx,
  input  logic [COORD_W-1:0] ty,
  output logic               hit
);
  assign hit = (px == tx) && (py == ty);
endmodule

// File: rtl/game_round_ctrl.sv
// game_round_ctrl: round sequencing, scoring and lives; GAME_ROUND_TIMEOUT_EN adds a per-round PLAY timeout
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int SCORE_W     = 8,
  parameter int LIVES_INIT  = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               fire,
  input  logic [COORD_W-1:0] player_x,
  input  logic [COORD_W-1:0] player_y,
  input  logic [COORD_W-1:0] target_x,
  input  logic [COORD_W-1:0] target_y,
  output logic               new_target,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic               round_active,
  output logic               game_over
);
  state_t state, next;
  logic hit, timeout, shot_hit, lose, restart;
  hit_detect u_hit (
    .px(player_x),
    .py(player_y),
    .tx(target_x),
    .ty(target_y),
    .hit(hit)
  );
`ifdef GAME_ROUND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] timer;
  // >= so that a miss landing on the last allowed cycle still times out on the next one
  assign timeout = (state == PLAY) && !fire && (timer >= TW'(TIMEOUT_CYC - 1));
  // round timer: zeroed while spawning, counts PLAY cycles
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) timer <= '0;
    else if (state == SPAWN) timer <= '0;
    else if (state == PLAY) timer <= timer + 1'b1;
`else
  assign timeout = 1'b0;
`endif
  assign shot_hit = (state == PLAY) && fire && hit;
  assign lose     = (state == PLAY) && ((fire && !hit) || timeout);
  assign restart  = ((state == IDLE) || (state == OVER)) && start;
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next;
  // next-state: a miss keeps the target, a timeout spawns a new one, losing the last life ends the game
  always_comb begin
    next = state;
    case (state)
      IDLE, OVER: next = start ? SPAWN : state;
      SPAWN:      next = PLAY;
      PLAY:       next = shot_hit ? SPAWN :
                         !lose ? PLAY :
                         (lives == LIVES_W'(1)) ? OVER :
                         fire ? PLAY : SPAWN;
      default:    next = IDLE;
    endcase
  end
  // score and lives bookkeeping; score saturates at all-ones
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      score <= '0;
      lives <= '0;
    end else if (restart) begin
      score <= '0;
      lives <= LIVES_W'(LIVES_INIT);
    end else if (shot_hit) begin
      score <= (&score) ? score : score + 1'b1;
    end else if (lose) begin
      lives <= lives - 1'b1;
    end
  // outputs decoded purely from state
  always_comb begin
    new_target   = (state == SPAWN);
    round_active = (state == PLAY);
    game_over    = (state == OVER);
  end
endmodule

// File: tb/tb_game_round_ctrl.sv
// tb_game_round_ctrl: directed vector table plus reset and timeout sequences
module tb_game_round_ctrl;
  logic       clk = 0, reset_n = 0, start = 0, fire = 0;
  logic [4:0] player_x = 0, player_y = 0, target_x = 7, target_y = 30;
  logic       new_target, round_active, game_over;
  logic [1:0] score, lives;
  int         n_tests = 0, n_fail = 0;

  typedef struct {
    logic       st, fi;
    logic [4:0] px, py, tx, ty;
    logic       nt, ra, go;
    logic [1:0] sc, lv;
  } vec_t;
  vec_t vq[$];

  game_round_ctrl #(.SCORE_W(2), .LIVES_INIT(3), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .fire(fire),
    .player_x(player_x), .player_y(player_y),
    .target_x(target_x), .target_y(target_y),
    .new_target(new_target), .score(score), .lives(lives),
    .round_active(round_active), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic add(input logic st, fi, input logic [4:0] px, py, tx, ty,
                     input logic nt, ra, go, input logic [1:0] sc, lv);
    vec_t v;
    v.st = st; v.fi = fi; v.px = px; v.py = py; v.tx = tx; v.ty = ty;
    v.nt = nt; v.ra = ra; v.go = go; v.sc = sc; v.lv = lv;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic nt, ra, go, input logic [1:0] sc, lv);
    n_tests++;
    if ({new_target, round_active, game_over, score, lives} !== {nt, ra, go, sc, lv}) begin
      n_fail++;
      $display("FAIL %s: got nt=%b ra=%b go=%b score=%0d lives=%0d, want nt=%b ra=%b go=%b score=%0d lives=%0d",
               name, new_target, round_active, game_over, score, lives, nt, ra, go, sc, lv);
    end
  endtask

  task automatic step(input logic st, fi, input logic [4:0] px, py, tx, ty);
    @(negedge clk);
    start = st; fire = fi; player_x = px; player_y = py; target_x = tx; target_y = ty;
    @(posedge clk);
    #1;
  endtask

  initial begin
    add(0,0, 0,0, 7,30,  0,0,0, 0,0);
    add(0,1, 7,30, 7,30, 0,0,0, 0,0);
    add(1,0, 0,0, 7,30,  1,0,0, 0,3);
    add(1,0, 0,0, 7,30,  0,1,0, 0,3);
    add(1,0, 0,0, 7,30,  0,1,0, 0,3);
    add(0,1, 7,30, 7,30, 1,0,0, 1,3);
    add(0,0, 7,30, 7,30, 0,1,0, 1,3);
    add(0,1, 7,30, 7,30, 1,0,0, 2,3);
    add(0,0, 7,30, 7,30, 0,1,0, 2,3);
    add(0,1, 7,30, 7,30, 1,0,0, 3,3);
    add(0,0, 7,30, 7,30, 0,1,0, 3,3);
    add(0,1, 7,30, 7,30, 1,0,0, 3,3);
    add(0,0, 7,30, 7,30, 0,1,0, 3,3);
    add(0,1, 7,30, 7,30, 1,0,0, 3,3);
    add(0,0, 7,30, 7,30, 0,1,0, 3,3);
    add(0,1, 8,30, 7,30, 0,1,0, 3,2);
    add(0,1, 7,29, 7,30, 0,1,0, 3,1);
    add(0,0, 8,30, 7,30, 0,1,0, 3,1);
    add(0,1, 8,30, 7,30, 0,0,1, 3,0);
    add(0,1, 7,30, 7,30, 0,0,1, 3,0);
    add(0,0, 7,30, 7,30, 0,0,1, 3,0);
    add(1,0, 7,30, 7,30, 1,0,0, 0,3);
    add(0,0, 7,30, 7,30, 0,1,0, 0,3);
    add(0,1, 1,2, 1,2,   1,0,0, 1,3);
    add(0,0, 1,2, 1,2,   0,1,0, 1,3);
    add(0,1, 1,2, 1,3,   0,1,0, 1,2);

    #2;
    check("reset_state", 0,0,0, 0,0);
    @(negedge clk);
    reset_n = 1;
    foreach (vq[i]) begin
      step(vq[i].st, vq[i].fi, vq[i].px, vq[i].py, vq[i].tx, vq[i].ty);
      check($sformatf("vec%0d", i), vq[i].nt, vq[i].ra, vq[i].go, vq[i].sc, vq[i].lv);
    end

    @(negedge clk);
    start = 0; fire = 0;
    reset_n = 0;
    #1;
    check("async_reset_mid_play", 0,0,0, 0,0);
    @(negedge clk);
    reset_n = 1;
    step(0,1, 7,30, 7,30);
    step(0,0, 7,30, 7,30);
    check("idle_after_reset", 0,0,0, 0,0);
    step(1,0, 7,30, 7,30);
    check("restart_spawn", 1,0,0, 0,3);
    step(0,0, 7,30, 7,30);
    check("restart_play", 0,1,0, 0,3);
    for (int k = 0; k < 3; k++) step(0,0, 7,30, 7,30);
    check("play_after_3_idle", 0,1,0, 0,3);
    step(0,0, 7,30, 7,30);
`ifdef GAME_ROUND_TIMEOUT_EN
    check("timeout_spawn", 1,0,0, 0,2);
    step(0,0, 7,30, 7,30);
    check("timeout_replay", 0,1,0, 0,2);
    for (int k = 0; k < 3; k++) step(0,0, 7,30, 7,30);
    check("timeout_pre_fire", 0,1,0, 0,2);
    step(0,1, 7,30, 7,30);
    check("fire_beats_timeout", 1,0,0, 1,2);
`else
    check("no_timeout_4", 0,1,0, 0,3);
    for (int k = 0; k < 8; k++) step(0,0, 7,30, 7,30);
    check("no_timeout_12", 0,1,0, 0,3);
    step(0,1, 7,30, 7,30);
    check("late_hit", 1,0,0, 1,3);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 Parameter SCORE_W, default 8, score counter width.
REQ-002 Parameter LIVES_INIT, default 3, lives loaded at game start (1..3).
REQ-003 Parameter TIMEOUT_CYC, default 1000, PLAY cycles before a round times out (>=2).
REQ-004 Port clk  input  1  sole clock, rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port start  input  1  single-cycle game start request.
REQ-007 Port fire  input  1  single-cycle player shot.
REQ-008 Port player_x / player_y  input  5 each  player cursor.
REQ-009 Port target_x / target_y  input  5 each  current target from target generator.
REQ-010 Port new_target  output  1  one-cycle enable to target generator (its result_valid).
REQ-011 Port score  output  SCORE_W  hit count.
REQ-012 Port lives  output  2  remaining lives.
REQ-013 Port round_active  output  1  high only in PLAY.
REQ-014 Port game_over  output  1  high only in OVER.

Function
REQ-015 The FSM SHALL have states IDLE, SPAWN, PLAY, OVER, encoded in 2 bits.
REQ-016 IDLE: start -> SPAWN with score cleared and lives loaded with LIVES_INIT; otherwise hold.
REQ-017 SPAWN SHALL last exactly one cycle, assert new_target for that cycle only, clear the round timer, then go to PLAY.
REQ-018 new_target SHALL be combinational from state==SPAWN, so target_x/target_y are valid from the first PLAY cycle.
REQ-019 PLAY, fire with player_x==target_x and player_y==target_y: hit; score+1, saturating at all-ones; -> SPAWN.
REQ-020 PLAY, fire with any coordinate mismatch: miss; lives-1; stay in PLAY on same target if result >0, else -> OVER.
REQ-021 Hit compare SHALL use the target_x/target_y values sampled in the same cycle as fire.
REQ-022 start SHALL be ignored in SPAWN and PLAY; fire SHALL be ignored outside PLAY.
REQ-023 OVER: score and lives hold; start -> SPAWN with score cleared and lives reloaded, same as REQ-016.
REQ-024 Round timer SHALL count PLAY cycles, width $clog2(TIMEOUT_CYC+1), cleared on every SPAWN entry.
REQ-025 Outputs SHALL all be registered or decoded from state; no input-to-output combinational path.

Reset
REQ-026 reset_n low SHALL asynchronously force state IDLE, score 0, lives 0, timer 0, new_target 0, round_active 0, game_over 0.
REQ-027 Reset asserted mid-round SHALL abandon the round; after release the block waits in IDLE for start.

Configuration
REQ-028 Macro GAME_ROUND_TIMEOUT_EN SHALL gate the round timeout feature.
REQ-029 Defined: timer reaching TIMEOUT_CYC-1 in PLAY without fire counts as a miss; lives-1; -> SPAWN if lives remain, else -> OVER.
REQ-030 Defined: fire in the same cycle as timeout SHALL take priority; the timeout is discarded.
REQ-031 Undefined: no timer logic present; PLAY waits indefinitely for fire.

Structure
REQ-032 Shared package game_pkg SHALL hold the state enum type, COORD_W=5, and LIVES_W=2.
REQ-033 Sub-module hit_detect (pure 5-bit x/y equality compare) SHALL be instantiated once; all else in one module.

Verification
REQ-034 Reset, start -> new_target high exactly one cycle after start; PLAY next cycle; lives=3, score=0.
REQ-035 PLAY, target (7,30), player (7,30), fire -> score=1, one new_target pulse, back in PLAY.
REQ-036 PLAY, player (8,30) vs target (7,30), fire three times -> lives 2,1,0; game_over high after third; further fire no effect.
REQ-037 With GAME_ROUND_TIMEOUT_EN and TIMEOUT_CYC=4, no fire -> after 4 PLAY cycles lives-1 and new_target pulses; fire on cycle 4 with a hit -> score+1, no life lost.
REQ-038 SCORE_W=2, 5 consecutive hits -> score stays 3.
REQ-039 reset_n pulsed low mid-PLAY -> outputs immediately zero, IDLE; start in OVER -> score 0, lives 3, SPAWN.
